digit_value_loader: RTL and testbench

//   Sequencer that feeds a row of NUM_DIGITS seven-segment digit renderers on the VGA path.

---
 rtl/digit_value_loader.sv | 121 ++++++++++++
 tb/tb_digit_value_loader.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/digit_value_loader.sv
// Binary-to-BCD loader for a row of seven-segment renderers: serial double-dabble
// conversion, with the new digits committed only on a frame boundary.
module digit_value_loader #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VAL_W-1:0]        in_value,
  input  logic                    frame_start,
  input  logic                    blank_lz,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    ovf,
  output logic                    busy
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;

  function automatic logic [63:0] maxDisplayable(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = maxDisplayable(NUM_DIGITS);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [VAL_W-1:0]      r_val;
  logic [BCD_W-1:0]      r_bcd;
  logic                  r_ovfPend;
  logic [BCD_W-1:0]      r_digits;
  logic [NUM_DIGITS-1:0] r_en;
  logic                  r_ovf;

  logic                  w_tooBig;
  logic [BCD_W-1:0]      w_bcdAdj;
  logic [NUM_DIGITS-1:0] w_nz;
  logic [NUM_DIGITS-1:0] w_lzEn;

  assign w_tooBig = 64'(in_value) > MAX_VAL;

  // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
  always_comb begin
    w_bcdAdj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // A digit is lit if it or any more-significant digit is nonzero; ones always lit.
  always_comb begin
    w_nz   = '0;
    w_lzEn = '0;
    for (int i = 0; i < NUM_DIGITS; i++) w_nz[i] = |r_bcd[4*i +: 4];
    for (int i = 0; i < NUM_DIGITS; i++) w_lzEn[i] = |(w_nz >> i);
    w_lzEn[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_val     <= '0;
      r_bcd     <= '0;
      r_ovfPend <= 1'b0;
      r_digits  <= '0;
      r_en      <= '1;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_val     <= in_value;
            r_bcd     <= '0;
            r_ovfPend <= w_tooBig;
            r_cnt     <= CNT_W'(VAL_W - 1);
            r_state   <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          r_bcd <= {w_bcdAdj[BCD_W-2:0], r_val[VAL_W-1]};
          r_val <= r_val << 1;
          if (r_cnt == '0) r_state <= ST_WAIT;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_WAIT: begin
          // Committing only here keeps the displayed digits stable for a whole frame.
          if (frame_start) begin
            r_ovf <= r_ovfPend;
            if (r_ovfPend) begin
              r_digits <= '1;
              r_en     <= '1;
            end else begin
              r_digits <= r_bcd;
              r_en     <= blank_lz ? w_lzEn : '1;
            end
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign digits_out = r_digits;
  assign digit_en   = r_en;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_digit_value_loader.sv
// Self-checking bench for digit_value_loader: directed scenarios plus randomized
// transactions compared against a decimal-arithmetic reference model.
module tb_digit_value_loader;

  localparam int ND = 4;
  localparam int VW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_value = '0;
  logic          frame_start = 1'b0;
  logic          blank_lz = 1'b0;
  logic [15:0]   digits_out;
  logic [3:0]    digit_en;
  logic          ovf;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] expDigits = 16'h0000;
  logic [3:0]  expEn     = 4'hF;
  logic        expOvf    = 1'b0;

  digit_value_loader #(.NUM_DIGITS(ND), .VAL_W(VW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .frame_start(frame_start), .blank_lz(blank_lz),
    .digits_out(digits_out), .digit_en(digit_en), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, overflow by range, blanking by highest nonzero digit.
  task automatic modelCommit(input int v, input bit blz);
    int hi;
    int dig;
    int p;
    if (v > 9999) begin
      expOvf = 1'b1; expDigits = 16'hFFFF; expEn = 4'hF;
    end else begin
      expOvf = 1'b0; hi = 0; p = 1;
      for (int i = 0; i < ND; i++) begin
        dig = (v / p) % 10;
        expDigits[4*i +: 4] = 4'(dig);
        if (dig != 0) hi = i;
        p = p * 10;
      end
      for (int i = 0; i < ND; i++) expEn[i] = !blz || (i <= hi);
    end
  endtask

  task automatic checkHeld(input string tag);
    checkOutput({tag, "_digits"}, 32'(digits_out), 32'(expDigits));
    checkOutput({tag, "_en"}, 32'(digit_en), 32'(expEn));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
  endtask

  // Runs from just after the handshake edge through the commit and its checks.
  task automatic finishTransaction(input int v, input bit blz, input int extra, input int early);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    for (int c = 1; c <= VW; c++) begin
      if (c == early) frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      checkOutput("ready_low_busy", 32'(in_ready), 32'd0);
      if (c == early) checkHeld("early_frame_ignored");
    end
    repeat (extra) begin
      @(posedge clk); #1;
    end
    checkOutput("busy_wait_frame", 32'(busy), 32'd1);
    checkHeld("held_before_commit");
    blank_lz = blz;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    modelCommit(v, blz);
    checkHeld("commit");
    checkOutput("ready_after_commit", 32'(in_ready), 32'd1);
  endtask

  task automatic applyStimulus(input int v, input bit blz, input int extra, input int early);
    checkOutput("ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_value = VW'(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    finishTransaction(v, blz, extra, early);
  endtask

  initial begin
    int v;
    bit blz;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkHeld("reset");
    checkOutput("reset_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    applyStimulus(1234, 1'b0, 2, 0);
    applyStimulus(7, 1'b1, 0, 0);
    applyStimulus(0, 1'b1, 1, 0);
    applyStimulus(10000, 1'b1, 0, 0);
    applyStimulus(9999, 1'b0, 0, 0);
    applyStimulus(16383, 1'b0, 0, 0);
    applyStimulus(305, 1'b1, 0, 5);

    // Back-to-back values with in_valid held high throughout.
    in_valid = 1'b1;
    in_value = VW'(4021);
    @(posedge clk); #1;
    in_value = VW'(80);
    finishTransaction(4021, 1'b1, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    finishTransaction(80, 1'b1, 0, 0);

    // Reset in the middle of a conversion discards the value in flight.
    in_valid = 1'b1;
    in_value = VW'(4321);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expDigits = 16'h0000; expEn = 4'hF; expOvf = 1'b0;
    checkHeld("mid_reset");
    checkOutput("mid_reset_ready", 32'(in_ready), 32'd1);
    applyStimulus(56, 1'b1, 0, 0);

    for (int n = 0; n < 30; n++) begin
      v = (n % 4 == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 16383));
      blz = 1'($urandom_range(0, 1));
      applyStimulus(v, blz, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, VW)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
